// File: rtl/video_pkg.sv
// Shared FSM state type and default-geometry constants for the line-prefetch path.
package video_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } fetch_state_t;

    localparam int DEF_ACTIVE_H_PIXELS = 1280;
    localparam int DEF_BURST_PIXELS    = 64;
    localparam int DEF_BYTES_PER_PIXEL = 4;

    localparam int BURST_BYTES     = DEF_BURST_PIXELS * DEF_BYTES_PER_PIXEL;
    localparam int BURSTS_PER_LINE = DEF_ACTIVE_H_PIXELS / DEF_BURST_PIXELS;

    function automatic int burst_bytes(input int burst_pixels, input int bytes_per_pixel);
        return burst_pixels * bytes_per_pixel;
    endfunction

endpackage

// File: rtl/video_fetch_scheduler_if.sv
// Burst read request/return channel between the fetch scheduler and the frame-buffer port.
// Request holds addr/len stable until acked; beats return one pixel per cycle, no backpressure.
interface video_fetch_scheduler_if #(
    parameter int ADDR_W = 32
);
    logic              rd_req_o;
    logic [ADDR_W-1:0] rd_addr_o;
    logic [7:0]        rd_len_o;
    logic              rd_ack_i;
    logic              rd_beat_i;

    modport master (
        output rd_req_o, rd_addr_o, rd_len_o,
        input  rd_ack_i, rd_beat_i
    );

    modport slave (
        input  rd_req_o, rd_addr_o, rd_len_o,
        output rd_ack_i, rd_beat_i
    );
endinterface

// File: rtl/video_fetch_addr_gen.sv
// Line-address and burst-address accumulators; burst address steps by one burst per accept.
// Registered: new line address visible the cycle after load, next burst address the cycle after advance.
module video_fetch_addr_gen #(
    parameter int ADDR_W   = 32,
    parameter int BURST_SZ = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              first,
    input  logic              advance,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] stride,
    output logic [ADDR_W-1:0] addr
);
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(BURST_SZ);

    logic [ADDR_W-1:0] line_addr;
    logic [ADDR_W-1:0] stride_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            line_addr <= '0;
            stride_q  <= '0;
            addr      <= '0;
        end else if (load) begin
            if (first) begin
                line_addr <= base;
                stride_q  <= stride;
                addr      <= base;
            end else begin
                line_addr <= line_addr + stride_q;
                addr      <= line_addr + stride_q;
            end
        end else if (advance) begin
            addr <= addr + STEP;
        end
    end

endmodule

// File: rtl/video_fetch_scheduler.sv
// Prefetches each active line into a ping-pong line buffer; optional VIDEO_FETCH_UNDERRUN_CNT_EN counter.
// Request rises 1 cycle after trigger, caps in-flight bursts at MAX_OUTSTANDING; bank ready 1 cycle after last beat.
module video_fetch_scheduler
    import video_pkg::*;
#(
    parameter int ACTIVE_H_PIXELS = DEF_ACTIVE_H_PIXELS,
    parameter int ACTIVE_LINES    = 720,
    parameter int TOTAL_LINES     = 750,
    parameter int HCNTR_BITS      = 11,
    parameter int VCNTR_BITS      = 10,
    parameter int BURST_PIXELS    = DEF_BURST_PIXELS,
    parameter int BYTES_PER_PIXEL = DEF_BYTES_PER_PIXEL,
    parameter int ADDR_W          = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  pxl_ce_i,
    input  logic [HCNTR_BITS-1:0] hcount_i,
    input  logic [VCNTR_BITS-1:0] vcount_i,
    input  logic [ADDR_W-1:0]     fb_base_i,
    input  logic [ADDR_W-1:0]     stride_i,
    video_fetch_scheduler_if.master rd,
    output logic                  wr_bank_o,
    output logic [HCNTR_BITS-1:0] wr_idx_o,
    output logic [1:0]            bank_ready_o,
    output logic                  underrun_o,
    output logic                  overlap_o,
    output logic [15:0]           underrun_cnt_o
);
    localparam int NUM_BURSTS = ACTIVE_H_PIXELS / BURST_PIXELS;
    localparam int BIDX_W     = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
    localparam int BEAT_W     = (BURST_PIXELS > 1) ? $clog2(BURST_PIXELS) : 1;
    localparam int OUT_W      = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [BIDX_W-1:0]     LAST_BIDX = BIDX_W'(NUM_BURSTS - 1);
    localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(BURST_PIXELS - 1);
    localparam logic [OUT_W-1:0]      MAX_OUT   = OUT_W'(MAX_OUTSTANDING);
    localparam logic [HCNTR_BITS-1:0] H_END     = HCNTR_BITS'(ACTIVE_H_PIXELS);
    localparam logic [VCNTR_BITS-1:0] V_ACT     = VCNTR_BITS'(ACTIVE_LINES);
    localparam logic [VCNTR_BITS-1:0] V_PREF    = VCNTR_BITS'(ACTIVE_LINES - 1);
    localparam logic [VCNTR_BITS-1:0] V_LAST    = VCNTR_BITS'(TOTAL_LINES - 1);

    fetch_state_t      state, state_nxt;
    logic [BIDX_W-1:0] burst_idx;
    logic [OUT_W-1:0]  outstanding, out_nxt;
    logic [BEAT_W-1:0] beat_cnt;

    logic t_first, t_next, trig, release_ev, check_ev;
    logic req, ack_ev, beat_ev, last_beat, start, done;

    assign t_first    = pxl_ce_i && (hcount_i == '0) && (vcount_i == V_LAST);
    assign t_next     = pxl_ce_i && (hcount_i == '0) && (vcount_i < V_PREF);
    assign trig       = t_first || t_next;
    assign release_ev = pxl_ce_i && (hcount_i == H_END) && (vcount_i < V_ACT);
    assign check_ev   = pxl_ce_i && (hcount_i == '0) && (vcount_i < V_ACT)
                        && !bank_ready_o[vcount_i[0]];

    // ISSUE is left on the final accept, so being in ISSUE already implies bursts remain.
    assign req       = (state == ISSUE) && (outstanding < MAX_OUT);
    assign ack_ev    = req && rd.rd_ack_i;
    assign beat_ev   = rd.rd_beat_i && (outstanding != '0);
    assign last_beat = beat_ev && (beat_cnt == LAST_BEAT);
    assign out_nxt   = outstanding + OUT_W'(ack_ev) - OUT_W'(last_beat);

    assign rd.rd_req_o = req;
    assign rd.rd_len_o = 8'(BURST_PIXELS - 1);

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (trig) begin
                    state_nxt = ISSUE;
                    start     = 1'b1;
                end
            end
            ISSUE: begin
                if (ack_ev && (burst_idx == LAST_BIDX)) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (out_nxt == '0) begin
                    state_nxt = IDLE;
                    done      = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= IDLE;
            burst_idx    <= '0;
            outstanding  <= '0;
            beat_cnt     <= '0;
            wr_idx_o     <= '0;
            wr_bank_o    <= 1'b0;
            bank_ready_o <= '0;
            underrun_o   <= 1'b0;
            overlap_o    <= 1'b0;
        end else begin
            state       <= state_nxt;
            outstanding <= out_nxt;

            if (start) begin
                burst_idx <= '0;
                wr_bank_o <= t_first ? 1'b0 : ~vcount_i[0];
            end else if (ack_ev) begin
                burst_idx <= burst_idx + BIDX_W'(1);
            end

            if (beat_ev) begin
                beat_cnt <= last_beat ? '0 : beat_cnt + BEAT_W'(1);
            end

            if (start || done) begin
                wr_idx_o <= '0;
            end else if (beat_ev) begin
                wr_idx_o <= wr_idx_o + HCNTR_BITS'(1);
            end

            // Completion wins over a release of the same bank.
            if (release_ev) begin
                bank_ready_o[vcount_i[0]] <= 1'b0;
            end
            if (done) begin
                bank_ready_o[wr_bank_o] <= 1'b1;
            end

            if (check_ev) begin
                underrun_o <= 1'b1;
            end
            if (trig && (state != IDLE)) begin
                overlap_o <= 1'b1;
            end
        end
    end

`ifdef VIDEO_FETCH_UNDERRUN_CNT_EN
    logic [15:0] urun_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            urun_cnt <= '0;
        end else if (check_ev && (urun_cnt != 16'hFFFF)) begin
            urun_cnt <= urun_cnt + 16'd1;
        end
    end

    assign underrun_cnt_o = urun_cnt;
`else
    assign underrun_cnt_o = '0;
`endif

    video_fetch_addr_gen #(
        .ADDR_W  (ADDR_W),
        .BURST_SZ(burst_bytes(BURST_PIXELS, BYTES_PER_PIXEL))
    ) u_addr_gen (
        .clk    (clk_i),
        .rst    (rst_i),
        .load   (start),
        .first  (t_first),
        .advance(ack_ev),
        .base   (fb_base_i),
        .stride (stride_i),
        .addr   (rd.rd_addr_o)
    );

endmodule

// File: tb/tb_video_fetch_scheduler.sv
// Directed bench for video_fetch_scheduler in a 16x4 (6 total lines) geometry, 4-pixel bursts, 2 in flight.
// Honours VIDEO_FETCH_UNDERRUN_CNT_EN for the expected underrun count.
module tb_video_fetch_scheduler;

    localparam int AW = 32;

`ifdef VIDEO_FETCH_UNDERRUN_CNT_EN
    localparam logic [15:0] UCNT_EXP = 16'd1;
`else
    localparam logic [15:0] UCNT_EXP = 16'd0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ce = 1'b0;
    logic [10:0]   hcount = '0;
    logic [9:0]    vcount = '0;
    logic [AW-1:0] fb_base = 32'h1000;
    logic [AW-1:0] stride = 32'h40;
    logic          wr_bank;
    logic [10:0]   wr_idx;
    logic [1:0]    bank_ready;
    logic          underrun;
    logic          overlap;
    logic [15:0]   ucnt;

    video_fetch_scheduler_if #(.ADDR_W(AW)) rd ();

    video_fetch_scheduler #(
        .ACTIVE_H_PIXELS(16), .ACTIVE_LINES(4), .TOTAL_LINES(6),
        .HCNTR_BITS(11), .VCNTR_BITS(10), .BURST_PIXELS(4),
        .BYTES_PER_PIXEL(4), .ADDR_W(AW), .MAX_OUTSTANDING(2)
    ) dut (
        .clk_i(clk), .rst_i(rst), .pxl_ce_i(ce), .hcount_i(hcount), .vcount_i(vcount),
        .fb_base_i(fb_base), .stride_i(stride), .rd(rd),
        .wr_bank_o(wr_bank), .wr_idx_o(wr_idx), .bank_ready_o(bank_ready),
        .underrun_o(underrun), .overlap_o(overlap), .underrun_cnt_o(ucnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ce;
        logic [10:0] h;
        logic [9:0]  v;
        logic        beat;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic [1:0]  exp_br;
        logic [10:0] exp_idx;
    } vec_t;

    vec_t        tbl[21];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] cap[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pix_event(input int h, input int v);
        rd.rd_beat_i = 1'b0;
        ce = 1'b1;
        hcount = 11'(h);
        vcount = 10'(v);
        step();
        ce = 1'b0;
    endtask

    // ack is held high, so any request seen here is accepted on the coming edge.
    task automatic mem_cycle(input logic beat);
        rd.rd_beat_i = beat;
        #1;
        if (rd.rd_req_o && rd.rd_ack_i) cap.push_back(rd.rd_addr_o);
        step();
    endtask

    function automatic vec_t mk(input logic c, input int h, input int v, input logic b,
                                input logic r, input int a, input int br, input int idx);
        vec_t t;
        t.ce = c; t.h = 11'(h); t.v = 10'(v); t.beat = b;
        t.exp_req = r; t.exp_addr = 32'(a); t.exp_br = 2'(br); t.exp_idx = 11'(idx);
        return t;
    endfunction

    initial begin
        // Line-0 prefetch: expected outputs are those visible when the row's inputs are applied.
        tbl[0]  = mk(1, 0, 5, 0, 0, 'h0000, 0, 0);
        tbl[1]  = mk(0, 0, 5, 0, 1, 'h1000, 0, 0);
        tbl[2]  = mk(0, 0, 5, 0, 1, 'h1010, 0, 0);
        tbl[3]  = mk(0, 0, 5, 1, 0, 'h1020, 0, 0);
        tbl[4]  = mk(0, 0, 5, 1, 0, 'h1020, 0, 1);
        tbl[5]  = mk(0, 0, 5, 1, 0, 'h1020, 0, 2);
        tbl[6]  = mk(0, 0, 5, 1, 0, 'h1020, 0, 3);
        tbl[7]  = mk(0, 0, 5, 1, 1, 'h1020, 0, 4);
        tbl[8]  = mk(0, 0, 5, 1, 0, 'h1030, 0, 5);
        tbl[9]  = mk(0, 0, 5, 1, 0, 'h1030, 0, 6);
        tbl[10] = mk(0, 0, 5, 1, 0, 'h1030, 0, 7);
        tbl[11] = mk(0, 0, 5, 1, 1, 'h1030, 0, 8);
        tbl[12] = mk(0, 0, 5, 0, 0, 'h1040, 0, 9);
        tbl[13] = mk(0, 0, 5, 1, 0, 'h1040, 0, 9);
        tbl[14] = mk(0, 0, 5, 1, 0, 'h1040, 0, 10);
        tbl[15] = mk(0, 0, 5, 1, 0, 'h1040, 0, 11);
        tbl[16] = mk(0, 0, 5, 1, 0, 'h1040, 0, 12);
        tbl[17] = mk(0, 0, 5, 1, 0, 'h1040, 0, 13);
        tbl[18] = mk(0, 0, 5, 1, 0, 'h1040, 0, 14);
        tbl[19] = mk(0, 0, 5, 1, 0, 'h1040, 0, 15);
        tbl[20] = mk(0, 0, 5, 0, 0, 'h1040, 1, 0);

        rd.rd_ack_i  = 1'b1;
        rd.rd_beat_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        chk("rst_req", 32'(rd.rd_req_o), 32'd0);
        chk("rst_addr", rd.rd_addr_o, 32'd0);
        chk("rst_len", 32'(rd.rd_len_o), 32'd3);
        chk("rst_wr_bank", 32'(wr_bank), 32'd0);
        chk("rst_wr_idx", 32'(wr_idx), 32'd0);
        chk("rst_bank_ready", 32'(bank_ready), 32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);
        chk("rst_overlap", 32'(overlap), 32'd0);
        chk("rst_ucnt", 32'(ucnt), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 21; i++) begin
            ce = tbl[i].ce;
            hcount = tbl[i].h;
            vcount = tbl[i].v;
            rd.rd_beat_i = tbl[i].beat;
            #1;
            chk($sformatf("row%0d_req", i), 32'(rd.rd_req_o), 32'(tbl[i].exp_req));
            chk($sformatf("row%0d_addr", i), rd.rd_addr_o, tbl[i].exp_addr);
            chk($sformatf("row%0d_bank_ready", i), 32'(bank_ready), 32'(tbl[i].exp_br));
            chk($sformatf("row%0d_wr_idx", i), 32'(wr_idx), 32'(tbl[i].exp_idx));
            step();
        end
        ce = 1'b0;
        rd.rd_beat_i = 1'b0;

        // Next line into bank 1, first with beats withheld to exercise the in-flight cap.
        cap.delete();
        pix_event(0, 0);
        chk("nl_underrun", 32'(underrun), 32'd0);
        chk("nl_wr_bank", 32'(wr_bank), 32'd1);
        repeat (6) mem_cycle(1'b0);
        chk("cap_accepted", 32'(cap.size()), 32'd2);
        chk("cap_req_low", 32'(rd.rd_req_o), 32'd0);
        repeat (16) mem_cycle(1'b1);
        rd.rd_beat_i = 1'b0;
        chk("nl_accepted", 32'(cap.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("nl_addr%0d", i), (i < cap.size()) ? cap[i] : 32'hDEAD_BEEF,
                32'h1040 + 32'(i * 16));
        chk("nl_bank_ready", 32'(bank_ready), 32'd3);
        chk("nl_wr_idx", 32'(wr_idx), 32'd0);
        pix_event(16, 0);
        chk("release0", 32'(bank_ready), 32'd2);

        // Line 2 left in DRAIN; line 1 released; next trigger overlaps and line 2 underruns.
        cap.delete();
        pix_event(0, 1);
        chk("l2_underrun_clear", 32'(underrun), 32'd0);
        chk("l2_wr_bank", 32'(wr_bank), 32'd0);
        repeat (4) mem_cycle(1'b0);
        repeat (12) mem_cycle(1'b1);
        rd.rd_beat_i = 1'b0;
        chk("l2_accepted", 32'(cap.size()), 32'd4);
        chk("l2_addr0", (cap.size() > 0) ? cap[0] : 32'hDEAD_BEEF, 32'h1080);
        chk("l2_not_ready", 32'(bank_ready), 32'd2);
        pix_event(16, 1);
        chk("release1", 32'(bank_ready), 32'd0);
        pix_event(0, 2);
        chk("ovl_overlap", 32'(overlap), 32'd1);
        chk("ovl_underrun", 32'(underrun), 32'd1);
        chk("ovl_ucnt", 32'(ucnt), 32'(UCNT_EXP));
        chk("ovl_req_low", 32'(rd.rd_req_o), 32'd0);
        repeat (4) mem_cycle(1'b1);
        rd.rd_beat_i = 1'b0;
        chk("ovl_old_done", 32'(bank_ready), 32'd1);
        repeat (3) mem_cycle(1'b0);
        chk("ovl_no_new_req", 32'(cap.size()), 32'd4);
        chk("ovl_sticky", 32'(overlap), 32'd1);

        // Reset in the middle of ISSUE, then stray beats.
        cap.delete();
        pix_event(0, 5);
        repeat (2) mem_cycle(1'b0);
        chk("mr_accepted", 32'(cap.size()), 32'd2);
        chk("mr_relatched", (cap.size() > 0) ? cap[0] : 32'hDEAD_BEEF, 32'h1000);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mr_req", 32'(rd.rd_req_o), 32'd0);
        chk("mr_addr", rd.rd_addr_o, 32'd0);
        chk("mr_len", 32'(rd.rd_len_o), 32'd3);
        chk("mr_wr_bank", 32'(wr_bank), 32'd0);
        chk("mr_wr_idx", 32'(wr_idx), 32'd0);
        chk("mr_bank_ready", 32'(bank_ready), 32'd0);
        chk("mr_underrun", 32'(underrun), 32'd0);
        chk("mr_overlap", 32'(overlap), 32'd0);
        chk("mr_ucnt", 32'(ucnt), 32'd0);
        repeat (3) mem_cycle(1'b1);
        rd.rd_beat_i = 1'b0;
        chk("stray_wr_idx", 32'(wr_idx), 32'd0);
        chk("stray_req", 32'(rd.rd_req_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/video_fetch_scheduler.md
# video_fetch_scheduler

Line-prefetch scheduler between the video timing generator and the frame-buffer memory read port. It watches the pixel counters and issues burst read requests so that each active line is in a two-bank ping-pong line buffer before the line is scanned out. It also tracks completion per bank and flags underruns and overlapping fetches.

## Interface
Parameters:
- ACTIVE_H_PIXELS, 1280: active pixels per line
- ACTIVE_LINES, 720: active lines per frame
- TOTAL_LINES, 750: total lines per frame
- HCNTR_BITS, 11 / VCNTR_BITS, 10: counter widths
- BURST_PIXELS, 64: pixels per read burst; must divide ACTIVE_H_PIXELS
- BYTES_PER_PIXEL, 4: pixel size in bytes
- ADDR_W, 32: memory byte-address width
- MAX_OUTSTANDING, 4: maximum number of bursts issued but not yet fully returned

Ports (one clock `clk_i`; reset `rst_i` is synchronous, active-high):
- clk_i, in, 1: system clock
- rst_i, in, 1: synchronous active-high reset
- pxl_ce_i, in, 1: pixel-advance enable; counters are valid on cycles where it is high
- hcount_i, in, HCNTR_BITS: horizontal pixel count
- vcount_i, in, VCNTR_BITS: vertical line count
- fb_base_i, in, ADDR_W: frame-buffer base address
- stride_i, in, ADDR_W: line stride in bytes
- rd_req_o, out, 1: burst request valid
- rd_addr_o, out, ADDR_W: burst start byte address
- rd_len_o, out, 8: burst length in beats (BURST_PIXELS-1 encoding)
- rd_ack_i, in, 1: request accepted
- rd_beat_i, in, 1: one returned pixel beat
- wr_bank_o, out, 1: line-buffer bank currently being filled
- wr_idx_o, out, HCNTR_BITS: pixel index within that bank for the current beat
- bank_ready_o, out, 2: per-bank "line complete" flags
- underrun_o, out, 1: sticky flag; an active line started without its data
- overlap_o, out, 1: sticky flag; a new fetch trigger arrived while a fetch was still in progress
- underrun_cnt_o, out, 16: saturating count of underruns (see Configuration)

## Operation
- Events are evaluated only on cycles with pxl_ce_i=1.
- **Trigger (T):**
  - On hcount=0 with vcount=TOTAL_LINES-1: fetch line 0. Latch fb_base_i and stride_i, and set the line address to fb_base_i.
  - On hcount=0 with vcount<ACTIVE_LINES-1: fetch line vcount+1. The line address advances by the latched stride.
  - The target bank is the fetched line number's bit 0.
- **Release (R):** on hcount=ACTIVE_H_PIXELS with vcount<ACTIVE_LINES, clear bank_ready[vcount[0]].
- **Check (C):** on hcount=0 with vcount<ACTIVE_LINES, if bank_ready[vcount[0]]=0, set underrun_o and increment the counter.
- T and C in the same cycle touch opposite banks and are independent.
- **FSM states:**
  - IDLE: on T, go to ISSUE.
  - ISSUE: hold rd_req_o high while outstanding<MAX_OUTSTANDING and bursts remain. On rd_req_o&&rd_ack_i, increment the burst index and outstanding count. When all ACTIVE_H_PIXELS/BURST_PIXELS bursts are issued, go to DRAIN.
  - DRAIN: wait until all beats have returned, then set bank_ready[target], go to IDLE.
- **Outstanding accounting:** rd_beat_i counts beats, and outstanding decrements when a burst's last beat arrives. A simultaneous ack and last-beat leaves outstanding unchanged.
- **Overlap:** T while not IDLE sets overlap_o. The new trigger is dropped, and the in-progress fetch continues to completion.
- **Spurious beats:** rd_beat_i when outstanding=0 is ignored. wr_idx_o does not advance.
- **Address:** rd_addr_o = line_addr + burst_idx·BURST_PIXELS·BYTES_PER_PIXEL, computed modulo 2^ADDR_W. No multiplier; it is accumulated by adding the burst byte size per ack.
- **Request rule:** rd_addr_o and rd_len_o stay stable while rd_req_o is high and not acked.

## Timing
- Reset values:
  - rd_req_o=0, rd_addr_o=0, rd_len_o=BURST_PIXELS-1
  - wr_bank_o=0, wr_idx_o=0
  - bank_ready_o=0
  - underrun_o=0, overlap_o=0, underrun_cnt_o=0
  - FSM in IDLE
- T to rd_req_o high: 1 cycle (registered).
- After an ack, the next request may be valid in the following cycle, so back-to-back bursts are allowed.
- Last beat to bank_ready set: 1 cycle.
- Reset mid-fetch:
  - Everything returns to reset values in the next cycle.
  - Beats still in flight are treated as spurious.
  - After reset, the first complete frame begins at vcount=TOTAL_LINES-1. Underruns before that are still flagged.

## Configuration
- `VIDEO_FETCH_UNDERRUN_CNT_EN` defined: underrun_cnt_o is a 16-bit counter that increments on each C failure, saturates at 0xFFFF, and is cleared only by reset.
- Not defined: the counter logic is omitted and underrun_cnt_o is tied to 0. underrun_o behaves identically in both builds.

## Structure
- Shared package video_pkg holds:
  - fetch_state_t enum (IDLE, ISSUE, DRAIN)
  - BURST_BYTES and BURSTS_PER_LINE localparams
- Sub-module: video_fetch_addr_gen, containing the line-address and burst-address accumulators.

## Test plan
Small configuration for all scenarios: ACTIVE_H_PIXELS=16, BURST_PIXELS=4, ACTIVE_LINES=4, TOTAL_LINES=6, fb_base=0x1000, stride=0x40.
- Line-0 prefetch: vcount=5, hcount=0, with rd_ack_i always high → four requests at addresses 0x1000, 0x1010, 0x1020, 0x1030. After 16 beats, bank_ready_o=01.
- Next-line fetch: at vcount=0, hcount=0 → addresses 0x1040–0x1070 go to bank 1, and underrun_o stays 0. At hcount=16 of line 0, bank_ready bit 0 clears.
- Outstanding cap: MAX_OUTSTANDING=2 with beats withheld → exactly 2 acked requests, then rd_req_o holds low until a burst's last beat arrives.
- Underrun: no beats returned for line 1 → at vcount=1, hcount=0, underrun_o=1 and underrun_cnt_o=1 (macro on) or 0 (macro off).
- Overlap: a line still in DRAIN at the next T → overlap_o=1, no new requests, and the old fetch completes.
- Reset mid-ISSUE: rst_i high for 1 cycle → the next cycle shows all reset values. 3 stray beats afterwards → wr_idx_o remains 0.
